// File: rtl/spio_spinnaker_link_sync_to_async_tx.sv
// SpiNNaker 2-of-7 link transmitter: buffers RTZ flits from the serializer and drives them as NRZ transitions.
// Optional ack watchdog enabled by defining SPIO_TX_ACK_TIMEOUT_EN.
module spio_spinnaker_link_sync_to_async_tx #(
  parameter int BUFF_DEPTH  = 4,
  parameter int ADDR_WIDTH  = 2,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic       CLK_IN,
  input  logic       rst,
  input  logic [6:0] flt_data_2of7,
  input  logic       flt_vld,
  output logic       flt_rdy,
  output logic [6:0] SL_DATA_2OF7_OUT,
  input  logic       SL_ACK_IN,
  output logic       drop_err,
  output logic       ack_timeout
);

  if ((1 << ADDR_WIDTH) != BUFF_DEPTH || BUFF_DEPTH < 2 || ACK_TIMEOUT < 1) begin : g_bad_cfg
    $error("BUFF_DEPTH must be 2**ADDR_WIDTH and >= 2; ACK_TIMEOUT must be >= 1");
  end

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t                state_q, state_d;
  logic [6:0]            mem_q [BUFF_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [6:0]            data_q, data_d;
  logic                  ack_meta_q, ack_s_q;
  logic                  ack_ref_q, ack_ref_d;
  logic                  drop_q, drop_d;
  logic                  full, empty, push, pop, ack_det, head_ok;
  logic [6:0]            head;

`ifdef SPIO_TX_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_q, tmo_d;
`endif

  assign full    = (count_q == (ADDR_WIDTH + 1)'(BUFF_DEPTH));
  assign empty   = (count_q == '0);
  assign flt_rdy = !full && !rst;
  assign push    = flt_vld && flt_rdy;
  assign head    = mem_q[rd_ptr_q];
  // At least two bits set: clearing the lowest set bit must leave something.
  assign head_ok = |(head & (head - 7'd1));
  assign ack_det = (ack_s_q != ack_ref_q);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    ack_ref_d = ack_ref_q;
    drop_d    = 1'b0;
    pop       = 1'b0;
`ifdef SPIO_TX_ACK_TIMEOUT_EN
    tmo_cnt_d = '0;
    tmo_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_ok) begin
            data_d    = data_q ^ head;
            ack_ref_d = ack_s_q;
            state_d   = WAIT_ACK;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (ack_det) begin
          if (empty) begin
            state_d = IDLE;
          end else begin
            pop = 1'b1;
            if (head_ok) begin
              data_d    = data_q ^ head;
              ack_ref_d = ack_s_q;
            end else begin
              drop_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
`ifdef SPIO_TX_ACK_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          // Give up on this flit; resync the reference so a late ack is not miscounted.
          tmo_d     = 1'b1;
          ack_ref_d = ack_s_q;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop);
    count_d  = count_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(pop);
  end

  always_ff @(posedge CLK_IN or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      ack_ref_q  <= 1'b0;
      drop_q     <= 1'b0;
`ifdef SPIO_TX_ACK_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      ack_meta_q <= SL_ACK_IN;
      ack_s_q    <= ack_meta_q;
      ack_ref_q  <= ack_ref_d;
      drop_q     <= drop_d;
`ifdef SPIO_TX_ACK_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (push) begin
      mem_q[wr_ptr_q] <= flt_data_2of7;
    end
  end

  assign SL_DATA_2OF7_OUT = data_q;
  assign drop_err         = drop_q;
`ifdef SPIO_TX_ACK_TIMEOUT_EN
  assign ack_timeout = tmo_q;
`else
  assign ack_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spio_spinnaker_link_sync_to_async_tx.sv
module tb_spio_spinnaker_link_sync_to_async_tx;

  logic       CLK_IN = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] flt_data_2of7 = '0;
  logic       flt_vld = 1'b0;
  logic       flt_rdy;
  logic [6:0] SL_DATA_2OF7_OUT;
  logic       SL_ACK_IN = 1'b0;
  logic       drop_err;
  logic       ack_timeout;

  spio_spinnaker_link_sync_to_async_tx #(
    .BUFF_DEPTH(4), .ADDR_WIDTH(2), .ACK_TIMEOUT(16)
  ) dut (
    .CLK_IN(CLK_IN), .rst(rst), .flt_data_2of7(flt_data_2of7), .flt_vld(flt_vld),
    .flt_rdy(flt_rdy), .SL_DATA_2OF7_OUT(SL_DATA_2OF7_OUT), .SL_ACK_IN(SL_ACK_IN),
    .drop_err(drop_err), .ack_timeout(ack_timeout)
  );

  always #5 CLK_IN = ~CLK_IN;

  int         n_cmp = 0;
  int         n_err = 0;
  int         drop_seen = 0;
  int         tmo_seen = 0;
  logic [6:0] exp_q[$];
  logic [6:0] nrz_model = '0;
  logic [6:0] prev_out = '0;
  logic       ack_lvl = 1'b0;

  typedef struct {
    logic [6:0] sym;
    logic       drop;
    logic [6:0] out;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    @(negedge CLK_IN);
  endtask

  function automatic logic valid_sym(input logic [6:0] s);
    return $countones(s) >= 2;
  endfunction

  task automatic model_accept(input logic [6:0] sym);
    if (valid_sym(sym)) begin
      nrz_model = nrz_model ^ sym;
      exp_q.push_back(nrz_model);
    end
  endtask

  task automatic send(input logic [6:0] sym);
    int w = 0;
    while (!flt_rdy && w < 20) begin
      tick();
      w++;
    end
    if (!flt_rdy) begin
      check("send_rdy_wait", {7'd0, flt_rdy}, 8'd1);
      return;
    end
    flt_vld = 1'b1;
    flt_data_2of7 = sym;
    tick();
    flt_vld = 1'b0;
    flt_data_2of7 = '0;
    model_accept(sym);
  endtask

  task automatic ack_and_wait();
    ack_lvl = !ack_lvl;
    SL_ACK_IN = ack_lvl;
    repeat (3) tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      ack_and_wait();
      tick();
    end
    ack_and_wait();
  endtask

  task automatic do_reset();
    flt_vld = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    nrz_model = '0;
    rst = 1'b0;
    repeat (3) tick();
  endtask

  // Scoreboard: every change on the link must be the next expected NRZ value.
  always @(negedge CLK_IN) begin
    if (rst) begin
      prev_out = '0;
    end else begin
      if (drop_err) drop_seen++;
      if (ack_timeout) tmo_seen++;
      if (SL_DATA_2OF7_OUT !== prev_out) begin
        if (exp_q.size() == 0) check("unexpected_tx", {1'b0, SL_DATA_2OF7_OUT}, {1'b0, prev_out});
        else check("sb_tx", {1'b0, SL_DATA_2OF7_OUT}, {1'b0, exp_q.pop_front()});
        prev_out = SL_DATA_2OF7_OUT;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] fsyms [6];
    int i, d0;
    logic acc;

    vecs[0] = '{7'h00, 1'b1, 7'h00};
    vecs[1] = '{7'h08, 1'b1, 7'h00};
    vecs[2] = '{7'h03, 1'b0, 7'h03};
    vecs[3] = '{7'h60, 1'b0, 7'h63};
    vecs[4] = '{7'h07, 1'b0, 7'h64};
    vecs[5] = '{7'h40, 1'b1, 7'h64};
    vecs[6] = '{7'h7F, 1'b0, 7'h1B};
    vecs[7] = '{7'h05, 1'b0, 7'h1E};
    fsyms = '{7'h03, 7'h05, 7'h06, 7'h09, 7'h0A, 7'h0C};

    // Reset state
    repeat (2) tick();
    check("rst_out", {1'b0, SL_DATA_2OF7_OUT}, 8'h00);
    check("rst_rdy", {7'd0, flt_rdy}, 8'd0);
    check("rst_drop", {7'd0, drop_err}, 8'd0);
    check("rst_tmo", {7'd0, ack_timeout}, 8'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("rdy_after_rst", {7'd0, flt_rdy}, 8'd1);

    // Symbol classification and NRZ accumulation, one flit at a time from IDLE
    foreach (vecs[v]) begin
      send(vecs[v].sym);
      tick();
      check($sformatf("vec%0d_out", v), {1'b0, SL_DATA_2OF7_OUT}, {1'b0, vecs[v].out});
      check($sformatf("vec%0d_drop", v), {7'd0, drop_err}, {7'd0, vecs[v].drop});
      if (!vecs[v].drop) begin
        repeat (2) tick();
        check($sformatf("vec%0d_hold", v), {1'b0, SL_DATA_2OF7_OUT}, {1'b0, vecs[v].out});
        ack_and_wait();
      end
    end

    // NRZ chain with exact ack-recognition latency
    do_reset();
    send(7'h03);
    tick();
    check("chain_first", {1'b0, SL_DATA_2OF7_OUT}, 8'h03);
    send(7'h05);
    repeat (4) tick();
    check("chain_hold", {1'b0, SL_DATA_2OF7_OUT}, 8'h03);
    ack_lvl = !ack_lvl;
    SL_ACK_IN = ack_lvl;
    repeat (2) tick();
    check("chain_early", {1'b0, SL_DATA_2OF7_OUT}, 8'h03);
    tick();
    check("chain_second", {1'b0, SL_DATA_2OF7_OUT}, 8'h06);
    drain();

    // Full FIFO: 1 in flight + 4 buffered, then backpressure
    do_reset();
    i = 0;
    for (int c = 0; c < 10; c++) begin
      flt_vld = 1'b1;
      flt_data_2of7 = fsyms[i];
      acc = flt_rdy;
      tick();
      if (acc) begin
        model_accept(fsyms[i]);
        i++;
      end
      if (i > 5) break;
    end
    check("full_accepted", 8'(i), 8'd5);
    check("full_rdy", {7'd0, flt_rdy}, 8'd0);
    check("full_out", {1'b0, SL_DATA_2OF7_OUT}, 8'h03);
    ack_lvl = !ack_lvl;
    SL_ACK_IN = ack_lvl;
    repeat (3) tick();
    check("full_next_tx", {1'b0, SL_DATA_2OF7_OUT}, 8'h06);
    check("full_rdy_again", {7'd0, flt_rdy}, 8'd1);
    tick();
    model_accept(fsyms[5]);
    flt_vld = 1'b0;
    drain();
    check("full_drained", 8'(exp_q.size()), 8'd0);

    // Invalid symbols dropped back-to-back, then a drop after an ack
    do_reset();
    d0 = drop_seen;
    flt_vld = 1'b1;
    flt_data_2of7 = 7'h00; tick(); model_accept(7'h00);
    flt_data_2of7 = 7'h08; tick(); model_accept(7'h08);
    flt_data_2of7 = 7'h18; tick(); model_accept(7'h18);
    flt_vld = 1'b0;
    tick();
    check("inv_out", {1'b0, SL_DATA_2OF7_OUT}, 8'h18);
    check("inv_drops", 8'(drop_seen - d0), 8'd2);
    send(7'h01);
    send(7'h03);
    ack_and_wait();
    repeat (2) tick();
    check("inv_wait_drop_out", {1'b0, SL_DATA_2OF7_OUT}, 8'h1B);
    check("inv_wait_drops", 8'(drop_seen - d0), 8'd3);
    drain();

    // Reset in WAIT_ACK with 3 flits queued
    do_reset();
    send(7'h03); send(7'h05); send(7'h06); send(7'h09);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out", {1'b0, SL_DATA_2OF7_OUT}, 8'h00);
    check("midrst_rdy", {7'd0, flt_rdy}, 8'd0);
    @(negedge CLK_IN);
    tick();
    exp_q.delete();
    nrz_model = '0;
    rst = 1'b0;
    repeat (4) tick();
    check("midrst_empty", {1'b0, SL_DATA_2OF7_OUT}, 8'h00);
    check("midrst_rdy_after", {7'd0, flt_rdy}, 8'd1);
    send(7'h60);
    tick();
    check("midrst_next", {1'b0, SL_DATA_2OF7_OUT}, 8'h60);
    ack_and_wait();
    repeat (4) tick();
    check("midrst_no_residue", {1'b0, SL_DATA_2OF7_OUT}, 8'h60);
    check("midrst_sb_empty", 8'(exp_q.size()), 8'd0);

    // Unacknowledged flit with a second one queued
    do_reset();
    flt_vld = 1'b1;
    flt_data_2of7 = 7'h03; tick(); model_accept(7'h03);
    flt_data_2of7 = 7'h05; tick(); model_accept(7'h05);
    flt_vld = 1'b0;
    check("tmo_first", {1'b0, SL_DATA_2OF7_OUT}, 8'h03);
`ifdef SPIO_TX_ACK_TIMEOUT_EN
    repeat (15) tick();
    check("tmo_not_yet", {7'd0, ack_timeout}, 8'd0);
    tick();
    check("tmo_pulse", {7'd0, ack_timeout}, 8'd1);
    check("tmo_out_kept", {1'b0, SL_DATA_2OF7_OUT}, 8'h03);
    tick();
    check("tmo_pulse_end", {7'd0, ack_timeout}, 8'd0);
    check("tmo_second", {1'b0, SL_DATA_2OF7_OUT}, 8'h06);
    drain();
    check("tmo_count", 8'(tmo_seen), 8'd1);
`else
    repeat (40) tick();
    check("noack_hold", {1'b0, SL_DATA_2OF7_OUT}, 8'h03);
    check("noack_tmo", 8'(tmo_seen), 8'd0);
    ack_and_wait();
    check("noack_second", {1'b0, SL_DATA_2OF7_OUT}, 8'h06);
    drain();
`endif
    check("final_sb_empty", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spio_spinnaker_link_sync_to_async_tx.md
Name: spio_spinnaker_link_sync_to_async_tx

Overview:
Transmit side of the SpiNNaker 2-of-7 link, the counterpart of the async-to-sync receive FIFO.
- Accepts 2-of-7 return-to-zero (RTZ) flit symbols from the synchronous packet serializer over a valid/ready handshake.
- Buffers them in a small synchronous FIFO.
- Drives them onto the asynchronous link as non-return-to-zero (NRZ) transitions, one flit per acknowledge toggle.
- Sits between the packet serializer and the SpiNNaker link pins.

Parameters:
- BUFF_DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_WIDTH, 2: log2(BUFF_DEPTH).
- ACK_TIMEOUT, 1023: cycles to wait for an acknowledge; used only with SPIO_TX_ACK_TIMEOUT_EN.

Ports:
- CLK_IN, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- flt_data_2of7, in, 7: RTZ 2-of-7 symbol from the serializer.
- flt_vld, in, 1: flt_data_2of7 is valid.
- flt_rdy, out, 1: block can accept a flit.
- SL_DATA_2OF7_OUT, out, 7: NRZ link data, registered.
- SL_ACK_IN, in, 1: asynchronous NRZ acknowledge from the link.
- drop_err, out, 1: one-cycle pulse when an invalid symbol is discarded.
- ack_timeout, out, 1: one-cycle pulse when an acknowledge times out (see Optional Feature).

Behaviour:
- Reset values:
  - SL_DATA_2OF7_OUT=0, flt_rdy=0 while rst is high, drop_err=0, ack_timeout=0.
  - FIFO empty; FSM in IDLE; ack synchronizer flops=0; ack_ref=0.
- Input handshake:
  - flt_rdy = !full && !rst. It is combinational from the occupancy count only; it never depends on flt_vld.
  - A transfer occurs on an edge where flt_vld && flt_rdy. Data is written at wr_ptr, wr_ptr increments, count increments.
- FIFO: binary read/write pointers wrap modulo BUFF_DEPTH; occupancy count is ADDR_WIDTH+1 bits.
  - full = (count==BUFF_DEPTH); empty = (count==0).
  - Push and pop on the same edge leave count unchanged.
  - Push is impossible while full (flt_rdy=0). Pop is impossible while empty.
- Symbol check at pop:
  - A FIFO head with popcount < 2 (0 or one-hot) is invalid. It is popped, not transmitted, and drop_err pulses for 1 cycle. The FSM stays in IDLE.
  - All other symbols, including EOP and symbols with 3 or more bits set, are transmitted unchanged.
- Ack synchronization:
  - SL_ACK_IN passes through a 2-flop synchronizer to give ack_s; ack_s is the only use of SL_ACK_IN.
  - An acknowledge is detected when ack_s != ack_ref.
- FSM states: IDLE, WAIT_ACK.
  - IDLE, !empty, valid head: on the edge, SL_DATA_2OF7_OUT <= SL_DATA_2OF7_OUT ^ head; pop; ack_ref <= ack_s; go to WAIT_ACK.
  - IDLE, !empty, invalid head: drop the head as described above; stay in IDLE.
  - IDLE, empty: hold.
  - WAIT_ACK, ack detected, FIFO empty: go to IDLE.
  - WAIT_ACK, ack detected, valid head: send the next flit on the same edge (XOR, pop, ack_ref <= ack_s); stay in WAIT_ACK.
  - WAIT_ACK, ack detected, invalid head: drop it and go to IDLE.
  - WAIT_ACK, no ack: hold. SL_DATA_2OF7_OUT never changes while in WAIT_ACK without an ack.
- Latency:
  - Flit accepted at edge N into an empty FIFO with FSM in IDLE: SL_DATA_2OF7_OUT changes at edge N+1.
  - An SL_ACK_IN toggle is recognised at most 3 edges after it arrives: 2 synchronizer edges plus 1 FSM edge.
  - Back-to-back flits therefore have no idle cycle between ack recognition and the next send.
- Reset mid-operation:
  - Reset at any time clears the FIFO, returns the FSM to IDLE and forces SL_DATA_2OF7_OUT=0. Any pending flit is lost.
  - The ack synchronizer is cleared; ack_ref is then reloaded from ack_s at the first send after reset.
- The FSM uses no combinational path from SL_ACK_IN to any output.

Optional Feature:
SPIO_TX_ACK_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_ACK and on every send. It increments each cycle in WAIT_ACK without an ack.
  - When the counter reaches ACK_TIMEOUT, ack_timeout pulses for 1 cycle, ack_ref <= ack_s, the FSM goes to IDLE, and the counter clears.
  - The flit is considered lost; it is not retransmitted, and SL_DATA_2OF7_OUT keeps its value.
- Not defined: there is no counter, ack_timeout is tied to 0, and WAIT_ACK waits indefinitely.

Test Plan:
- Single flit: after reset, send flit 7'b0000011 -> SL_DATA_2OF7_OUT=7'b0000011 one edge after acceptance. Toggle SL_ACK_IN 0->1 -> FSM back in IDLE within 3 edges.
- NRZ chain: send 7'b0000011, then 7'b0000101, with an ack toggle after each -> SL_DATA_2OF7_OUT goes 0x03, then 0x06. The output never changes before the corresponding ack.
- Full FIFO: hold SL_ACK_IN constant and present 6 flits -> 1 in flight plus 4 buffered accepted, then flt_rdy=0. One ack toggle -> next flit transmitted and flt_rdy=1 on the following cycle.
- Invalid symbol: push 7'b0000000, then 7'b0001000, then 7'b0011000 -> drop_err pulses twice, and only 0x18 is transmitted.
- Reset mid-flight: assert rst in WAIT_ACK with 3 flits queued -> SL_DATA_2OF7_OUT=0, flt_rdy=0 during reset, FIFO empty afterwards. The next flit 7'b1100000 is output as 0x60.
- Timeout (with SPIO_TX_ACK_TIMEOUT_EN, ACK_TIMEOUT=16): send one flit with no ack -> ack_timeout pulses 16 cycles after entering WAIT_ACK. A queued second flit is then sent on the next edge.
